// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the instruction/data SRAM port arbiter.
//   owner_e           : which CPU port owns an in-flight access
//   tag_t             : per-stage bookkeeping {valid, owner, is_write, killed}
//   TAG_IDLE          : empty stage value
//   DEFAULT_ADDR_MASK : kseg fold applied to every issued address
//   apply_kill()      : marks a valid fetch-owned tag as killed when kill is high
package mem_arb_pkg;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   is_write;
        logic   killed;
    } tag_t;

    localparam logic [31:0] DEFAULT_ADDR_MASK = 32'h1FFF_FFFF;

    localparam tag_t TAG_IDLE = '{valid: 1'b0, owner: OWN_INST, is_write: 1'b0, killed: 1'b0};

    // Data accesses belong to older instructions and are never killed.
    function automatic tag_t apply_kill(input tag_t t, input logic kill);
        tag_t r;
        r = t;
        if (kill && t.valid && (t.owner == OWN_INST)) begin
            r.killed = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_tag_pipe.sv
// arb_tag_pipe: MEM_LAT-deep tag shift register tracking in-flight accesses so
// each memory response can be routed back to its owner.
//   clk, resetn    : clock, asynchronous active-low reset (clears every stage)
//   push           : an access is issued this cycle (enters stage 0)
//   push_owner     : owner of the pushed access (owner_e encoding)
//   push_write     : pushed access is a store
//   kill           : kill every in-flight fetch (the one pushed now survives)
//   tail_*         : oldest stage, whose memory data is valid this cycle
//   busy           : any stage valid
module arb_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 1
)
(
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic push_owner,
    input  logic push_write,
    input  logic kill,
    output logic tail_valid,
    output logic tail_owner,
    output logic tail_write,
    output logic tail_killed,
    output logic busy
);

    tag_t stage_q [MEM_LAT];
    tag_t stage_d [MEM_LAT];
    tag_t tail_now;

    // Stage 0 takes the new access unkilled: a fetch granted together with a
    // flush belongs to the redirected stream. Older stages pick up the kill
    // as they shift.
    always_comb begin
        for (int i = 0; i < MEM_LAT; i++) begin
            stage_d[i] = TAG_IDLE;
        end
        if (push) begin
            stage_d[0].valid    = 1'b1;
            stage_d[0].owner    = owner_e'(push_owner);
            stage_d[0].is_write = push_write;
        end
        for (int i = 1; i < MEM_LAT; i++) begin
            stage_d[i] = apply_kill(stage_q[i-1], kill);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                stage_q[i] <= TAG_IDLE;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    // The tail is responding this cycle; a flush arriving now suppresses it
    // too, since the fetch it belongs to is being thrown away.
    assign tail_now    = apply_kill(stage_q[MEM_LAT-1], kill);
    assign tail_valid  = tail_now.valid;
    assign tail_owner  = tail_now.owner;
    assign tail_write  = tail_now.is_write;
    assign tail_killed = tail_now.killed;

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < MEM_LAT; i++) begin
            busy = busy | stage_q[i].valid;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port fixed-latency SRAM between the CPU
// fetch port (inst_*) and data port (data_*).
//   clk, resetn            : clock, asynchronous active-low reset
//   inst_req/addr/gnt      : fetch request handshake
//   inst_rvalid/rdata      : fetch response (rdata held when not valid)
//   inst_flush             : kill all fetches already issued
//   data_req/wen/addr/wdata/gnt : data request handshake (wen == 0 is a load)
//   data_rvalid/rdata      : load data or store-complete pulse (rdata 0 for stores)
//   mem_en/wen/addr/wdata  : memory macro strobe and write side
//   mem_rdata              : memory read data, valid MEM_LAT cycles after mem_en
//   busy                   : any access in flight
// Parameters: MEM_LAT (1..4), ADDR_MASK, STARVE_MAX.
// Optional macro MEM_ARB_FAIR_EN: after STARVE_MAX consecutive data grants
// while a fetch waits, the fetch wins once.
//
// Handshake: a requester raises req with its address/payload and holds them
// stable until it sees gnt high in the same cycle; the access is accepted in
// that cycle. gnt is combinational from req and is forced low in reset.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          MEM_LAT    = 1,
    parameter logic [31:0] ADDR_MASK  = DEFAULT_ADDR_MASK,
    parameter int          STARVE_MAX = 4
)
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_gnt,
    output logic        inst_rvalid,
    output logic [31:0] inst_rdata,
    input  logic        inst_flush,
    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,
    output logic        mem_en,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    logic        pick_data;
    logic        pick_inst;
    logic        inst_starved;
    logic        tail_valid;
    logic        tail_owner;
    logic        tail_write;
    logic        tail_killed;
    logic        resp_ok;
    logic [31:0] data_resp;
    logic [31:0] inst_hold_q;
    logic [31:0] data_hold_q;

`ifdef MEM_ARB_FAIR_EN
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    logic [STARVE_W-1:0] starve_cnt_q;

    assign inst_starved = (starve_cnt_q == STARVE_W'(STARVE_MAX));

    // Counts data grants that overtook a waiting fetch.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt_q <= '0;
        end else if (!inst_req || pick_inst) begin
            starve_cnt_q <= '0;
        end else if (pick_data) begin
            starve_cnt_q <= starve_cnt_q + STARVE_W'(1);
        end
    end
`else
    logic unused_starve_max;
    assign inst_starved      = 1'b0;
    assign unused_starve_max = ^STARVE_MAX;
`endif

    // Data wins by default: it belongs to the older instruction, so letting
    // fetches through first could deadlock the pipeline.
    assign pick_data = resetn & data_req & ~(inst_starved & inst_req);
    assign pick_inst = resetn & inst_req & ~pick_data;

    assign inst_gnt  = pick_inst;
    assign data_gnt  = pick_data;
    assign mem_en    = pick_inst | pick_data;
    assign mem_addr  = pick_data ? (data_addr & ADDR_MASK) :
                       pick_inst ? (inst_addr & ADDR_MASK) : 32'h0;
    assign mem_wen   = pick_data ? data_wen   : 4'h0;
    assign mem_wdata = pick_data ? data_wdata : 32'h0;

    arb_tag_pipe #(
        .MEM_LAT (MEM_LAT)
    ) u_tag_pipe (
        .clk         (clk),
        .resetn      (resetn),
        .push        (mem_en),
        .push_owner  (pick_data),
        .push_write  (pick_data & (|data_wen)),
        .kill        (inst_flush),
        .tail_valid  (tail_valid),
        .tail_owner  (tail_owner),
        .tail_write  (tail_write),
        .tail_killed (tail_killed),
        .busy        (busy)
    );

    assign resp_ok     = tail_valid & ~tail_killed;
    assign inst_rvalid = resp_ok & (tail_owner == logic'(OWN_INST));
    assign data_rvalid = resp_ok & (tail_owner == logic'(OWN_DATA));
    assign data_resp   = tail_write ? 32'h0 : mem_rdata;

    // Read data passes straight through in the response cycle; between
    // responses the last delivered word is held.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_hold_q <= 32'h0;
            data_hold_q <= 32'h0;
        end else begin
            if (inst_rvalid) begin
                inst_hold_q <= mem_rdata;
            end
            if (data_rvalid) begin
                data_hold_q <= data_resp;
            end
        end
    end

    assign inst_rdata = inst_rvalid ? mem_rdata : inst_hold_q;
    assign data_rdata = data_rvalid ? data_resp : data_hold_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios followed by random traffic for
// mem_port_arbiter. The reference model keeps a log of issued accesses per
// cycle and flush/reset history, and derives grants, memory-side outputs and
// responses from those records.
module tb_mem_port_arbiter;

    localparam int          LAT    = 3;
    localparam logic [31:0] MASK   = 32'h1FFF_FFFF;
    localparam int          STARVE = 4;
`ifdef MEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_gnt;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;
    logic        inst_flush;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    mem_port_arbiter #(
        .MEM_LAT    (LAT),
        .ADDR_MASK  (MASK),
        .STARVE_MAX (STARVE)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_gnt    (inst_gnt),
        .inst_rvalid (inst_rvalid),
        .inst_rdata  (inst_rdata),
        .inst_flush  (inst_flush),
        .data_req    (data_req),
        .data_wen    (data_wen),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_gnt    (data_gnt),
        .data_rvalid (data_rvalid),
        .data_rdata  (data_rdata),
        .mem_en      (mem_en),
        .mem_wen     (mem_wen),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory device: content is a function of address ----------------
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h1FC0_0000) return 32'h2402_0001;
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
    endfunction

    logic [31:0] dl [LAT];
    always @(posedge clk) begin
        dl[0] <= mem_en ? mem_fn(mem_addr) : 32'hBAD0_BAD0;
        for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
    end
    assign mem_rdata = dl[LAT-1];

    // ---------------- reference model state ----------------
    typedef struct {
        bit          is_data;
        bit          is_write;
        logic [31:0] addr;
    } acc_t;

    acc_t        issued [int];
    bit          flush_at [int];
    int          last_reset = -1;
    int          cyc = 0;
    int          starve = 0;
    bit          exp_ig = 1'b0;
    bit          exp_dg = 1'b0;
    logic [31:0] exp_addr;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic begin_cycle();
        bit          irv, drv, killed, busy_e;
        logic [31:0] ird, drd;
        int          c;
        exp_ig = 1'b0;
        exp_dg = 1'b0;
        if (resetn) begin
            if (data_req && !(FAIR && starve == STARVE && inst_req)) exp_dg = 1'b1;
            else if (inst_req) exp_ig = 1'b1;
        end else begin
            last_reset = cyc;
        end
        exp_addr = exp_dg ? (data_addr & MASK) : exp_ig ? (inst_addr & MASK) : 32'h0;
        flush_at[cyc] = inst_flush;

        // The access issued LAT cycles ago answers now unless reset dropped
        // it or a flush hit it while in flight (including this cycle).
        irv = 1'b0; drv = 1'b0; ird = '0; drd = '0;
        c = cyc - LAT;
        if (c > last_reset && issued.exists(c)) begin
            killed = 1'b0;
            if (!issued[c].is_data)
                for (int t = c + 1; t <= cyc; t++)
                    if (flush_at.exists(t) && flush_at[t]) killed = 1'b1;
            if (!killed) begin
                if (issued[c].is_data) begin
                    drv = 1'b1;
                    drd = issued[c].is_write ? 32'h0 : mem_fn(issued[c].addr);
                end else begin
                    irv = 1'b1;
                    ird = mem_fn(issued[c].addr);
                end
            end
        end
        busy_e = 1'b0;
        for (int k = cyc - LAT; k < cyc; k++)
            if (k > last_reset && issued.exists(k)) busy_e = 1'b1;

        #1;
        chk("inst_gnt", inst_gnt, exp_ig);
        chk("data_gnt", data_gnt, exp_dg);
        chk("mem_en", mem_en, exp_ig | exp_dg);
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_wen", mem_wen, exp_dg ? data_wen : 4'h0);
        chk("mem_wdata", mem_wdata, exp_dg ? data_wdata : 32'h0);
        chk("busy", busy, busy_e);
        chk("inst_rvalid", inst_rvalid, irv);
        chk("data_rvalid", data_rvalid, drv);
        if (irv) chk("inst_rdata", inst_rdata, ird);
        if (drv) chk("data_rdata", data_rdata, drd);
        if (!resetn) begin
            chk("inst_rdata_rst", inst_rdata, 32'h0);
            chk("data_rdata_rst", data_rdata, 32'h0);
        end
    endtask

    task automatic end_cycle();
        if (exp_ig || exp_dg)
            issued[cyc] = '{exp_dg, exp_dg && (data_wen != 4'h0), exp_addr};
        if (!resetn || !inst_req || exp_ig) starve = 0;
        else if (exp_dg) starve++;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic cycle();
        begin_cycle();
        end_cycle();
    endtask

    task automatic idle(input int n);
        inst_req = 1'b0;
        data_req = 1'b0;
        inst_flush = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        resetn = 1'b0; inst_req = 1'b0; inst_addr = '0; inst_flush = 1'b0;
        data_req = 1'b0; data_wen = '0; data_addr = '0; data_wdata = '0;
        @(negedge clk);

        // Reset: everything quiet, grants forced low even with requests up.
        cycle();
        inst_req = 1'b1; data_req = 1'b1; inst_addr = 32'h8000_0000; data_addr = 32'h8000_0004;
        begin_cycle();
        chk("rst_gnt_forced", {inst_gnt, data_gnt}, 2'b00);
        end_cycle();
        resetn = 1'b1;
        idle(1);

        // Single fetch from the boot vector.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        begin_cycle();
        chk("boot_mem_addr", mem_addr, 32'h1FC0_0000);
        end_cycle();
        idle(LAT - 1);
        begin_cycle();
        chk("boot_rvalid", inst_rvalid, 1'b1);
        chk("boot_rdata", inst_rdata, 32'h2402_0001);
        end_cycle();

        // Simultaneous requests: data first, fetch on the next cycle.
        inst_req = 1'b1; inst_addr = 32'h8000_0100;
        data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h8000_0010;
        begin_cycle();
        chk("both_data_first", {data_gnt, inst_gnt}, 2'b10);
        end_cycle();
        data_req = 1'b0;
        begin_cycle();
        chk("both_inst_next", inst_gnt, 1'b1);
        end_cycle();
        idle(LAT - 2);
        begin_cycle();
        chk("both_data_resp", {data_rvalid, inst_rvalid}, 2'b10);
        end_cycle();
        begin_cycle();
        chk("both_inst_resp", {data_rvalid, inst_rvalid}, 2'b01);
        end_cycle();

        // Three back-to-back fetches, flush alongside the third grant.
        inst_req = 1'b1; inst_addr = 32'h8000_0200; cycle();
        inst_addr = 32'h8000_0204; cycle();
        inst_addr = 32'h8000_0208; inst_flush = 1'b1; cycle();
        inst_flush = 1'b0;
        idle(LAT - 1);
        begin_cycle();
        chk("flush_survivor", inst_rvalid, 1'b1);
        end_cycle();

        // Partial store.
        data_req = 1'b1; data_wen = 4'b0011; data_addr = 32'h8000_0020; data_wdata = 32'h1234_5678;
        begin_cycle();
        chk("store_wen", mem_wen, 4'b0011);
        chk("store_wdata", mem_wdata, 32'h1234_5678);
        end_cycle();
        idle(LAT - 1);
        begin_cycle();
        chk("store_done", {data_rvalid, inst_rvalid}, 2'b10);
        chk("store_rdata", data_rdata, 32'h0);
        end_cycle();

        // Reset with two accesses in flight.
        data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h8000_0030;
        inst_req = 1'b1; inst_addr = 32'h8000_0300;
        cycle();
        data_req = 1'b0;
        cycle();
        resetn = 1'b0; data_req = 1'b1;
        begin_cycle();
        chk("rst_busy", busy, 1'b0);
        end_cycle();
        cycle();
        resetn = 1'b1;
        idle(LAT + 1);
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        begin_cycle();
        chk("post_rst_gnt", inst_gnt, 1'b1);
        end_cycle();
        idle(LAT);

        // Random traffic obeying the hold-until-grant rule.
        for (int n = 0; n < 500; n++) begin
            if (!(inst_req && !exp_ig)) begin
                inst_req  = ($urandom_range(0, 3) != 0);
                inst_addr = $urandom;
            end
            if (!(data_req && !exp_dg)) begin
                data_req   = ($urandom_range(0, 2) == 0);
                data_wen   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                data_addr  = $urandom;
                data_wdata = $urandom;
            end
            inst_flush = ($urandom_range(0, 7) == 0);
            cycle();
        end
        idle(LAT + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
